// File: rtl/nios2_system_timer_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the timer scheduler.
// No ports: imported by the scheduler top and its sub-blocks.
package nios2_system_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam logic [15:0] START_ITO = 16'h0005;
  localparam logic [15:0] STOP      = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_ST,
    WR_CTL,
    WAIT_IRQ,
    WR_STOP,
    WR_ACK,
    DONE
  } state_e;

  function automatic logic is_wr(input state_e s);
    return (s == WR_PL) || (s == WR_PH) || (s == WR_ST) ||
           (s == WR_CTL) || (s == WR_STOP) || (s == WR_ACK);
  endfunction

endpackage

// File: rtl/nios2_system_timer_scheduler_if.sv
// Register-bus link between the scheduler (master) and the interval timer (slave).
// Signals: tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tmr_irq.
interface nios2_system_timer_scheduler_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/nios2_system_timer_scheduler_arb.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; valid (any pick), idx (picked channel) out.
module nios2_system_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);
  int c;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c[CH_W-1:0];
      end
    end
  end
endmodule

// File: rtl/nios2_system_timer_scheduler.sv
// Shares one interval timer among NUM_CH requesters: grant, program, wait irq, report.
// Ports: clk/reset_n, req/period_in/cancel in, grant/done/done_cancelled/busy/active_ch out, tmr bus.
module nios2_system_timer_scheduler
  import nios2_system_timer_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*32-1:0] period_in,
  input  logic [NUM_CH-1:0]    cancel,
  output logic [NUM_CH-1:0]    grant,
  output logic [NUM_CH-1:0]    done,
  output logic                 done_cancelled,
  output logic                 busy,
  output logic [CH_W-1:0]      active_ch,
  nios2_system_timer_scheduler_if.master tmr
);

  state_e state_q, state_d;

  logic [CH_W-1:0]   ptr_q, ptr_d, ch_q, ch_d, nxt_ch;
  logic [31:0]       per_q, per_d;
  logic              cncl_q, cncl_d;
  logic [NUM_CH-1:0] grant_q, grant_d, done_q, done_d;
  logic              dc_q, dc_d, busy_q, busy_d;
  logic              cs_q, cs_d, wn_q, wn_d;
  logic [2:0]        addr_q, addr_d;
  logic [15:0]       wd_q, wd_d;

  logic              in_done, arb_en, arb_vld, take;
  logic [NUM_CH-1:0] arb_req;
  logic [CH_W-1:0]   arb_ptr, arb_idx;

  // Arbitrate in IDLE (once per grant) and also in DONE so the next
  // grant lands the cycle after done. In DONE the finishing channel is
  // masked: its req is still high until it sees done.
  assign in_done = (state_q == DONE);
  assign nxt_ch  = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  assign arb_en  = ((state_q == IDLE) && !(|grant_q)) || in_done;
  assign arb_ptr = in_done ? nxt_ch : ptr_q;
  assign arb_req = req & ~(in_done ? (NUM_CH'(1) << ch_q) : '0);
  assign take    = arb_en && arb_vld;

  nios2_system_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .valid (arb_vld),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (|grant_q) state_d = (per_q == 32'd0) ? DONE : WR_PL;
      WR_PL:    state_d = WR_PH;
      WR_PH:    state_d = WR_ST;
      WR_ST:    state_d = WR_CTL;
      WR_CTL:   state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (tmr.tmr_irq)        state_d = WR_ACK;
        else if (cancel[ch_q])  state_d = WR_STOP;
      end
      WR_STOP:  state_d = WR_ACK;
      WR_ACK:   state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from state_d so they line up with state_q.
  always_comb begin
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    per_d   = per_q;
    cncl_d  = cncl_q;
    grant_d = '0;
    if (take) begin
      grant_d = NUM_CH'(1) << arb_idx;
      ch_d    = arb_idx;
      per_d   = period_in[32*arb_idx +: 32];
      cncl_d  = 1'b0;
    end
    if (in_done)              ptr_d  = nxt_ch;
    if (state_d == WR_STOP)   cncl_d = 1'b1;

    done_d = (state_d == DONE) ? (NUM_CH'(1) << ch_q) : '0;
    dc_d   = (state_d == DONE) && cncl_q;
    busy_d = (state_d != IDLE);

    cs_d   = is_wr(state_d);
    wn_d   = !cs_d;
    addr_d = ADDR_STATUS;
    wd_d   = '0;
    unique case (1'b1)
      state_d == WR_PL:   begin addr_d = ADDR_PERIOD_L; wd_d = per_q[15:0];  end
      state_d == WR_PH:   begin addr_d = ADDR_PERIOD_H; wd_d = per_q[31:16]; end
      state_d == WR_CTL:  begin addr_d = ADDR_CONTROL;  wd_d = START_ITO;    end
      state_d == WR_STOP: begin addr_d = ADDR_CONTROL;  wd_d = STOP;         end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      ch_q    <= '0;
      per_q   <= '0;
      cncl_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      per_q   <= per_d;
      cncl_q  <= cncl_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign grant              = grant_q;
  assign done               = done_q;
  assign done_cancelled     = dc_q;
  assign busy               = busy_q;
  assign active_ch          = ch_q;
  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = wn_q;
  assign tmr.tmr_writedata  = wd_q;

endmodule

// File: tb/tb_nios2_system_timer_scheduler.sv
// Bench for nios2_system_timer_scheduler with a behavioural interval timer.
// Stimulus pushes expected grant/done/bus-write events; a monitor pops and compares.
module tb_nios2_system_timer_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   cancel = '0;
  logic [N*32-1:0] period = '0;
  logic [N-1:0]   grant, done;
  logic           done_cancelled, busy;
  logic [1:0]     active_ch;

  nios2_system_timer_scheduler_if tif();

  nios2_system_timer_scheduler #(.NUM_CH(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .period_in      (period),
    .cancel         (cancel),
    .grant          (grant),
    .done           (done),
    .done_cancelled (done_cancelled),
    .busy           (busy),
    .active_ch      (active_ch),
    .tmr            (tif.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer: period writes stop and reload, status write clears
  // timeout, control START runs one-shot down to zero.
  logic        t_rst = 1'b1;
  logic [31:0] t_per, t_cnt;
  logic        t_run, t_to, t_ito;

  always @(posedge clk) begin
    if (t_rst) begin
      t_per <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1; t_cnt <= t_per; t_run <= 1'b0;
        end else t_cnt <= t_cnt - 1;
      end
      if (tif.tmr_chipselect && !tif.tmr_write_n) begin
        case (tif.tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= tif.tmr_writedata[0];
            if (tif.tmr_writedata[3])      t_run <= 1'b0;
            else if (tif.tmr_writedata[2]) t_run <= 1'b1;
          end
          3'd2: begin
            t_per[15:0] <= tif.tmr_writedata;
            t_cnt <= {t_per[31:16], tif.tmr_writedata};
            t_run <= 1'b0;
          end
          3'd3: begin
            t_per[31:16] <= tif.tmr_writedata;
            t_cnt <= {tif.tmr_writedata, t_per[15:0]};
            t_run <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign tif.tmr_irq = t_to & t_ito;

  // kind 0 grant(a=ch), 1 done(a=ch, dc), 2 write(a=addr, d=data, dc=write_n)
  // rel 0 = cycles after last grant, 1 = after last done; dly<0 = untimed
  typedef struct {
    int kind; int a; int d; int dc; int rel; int dly;
  } ev_t;

  ev_t q[$];
  int checks = 0, errors = 0, evn = 0;
  int last_g = 0, last_d = 0;

  task automatic push(input int k, a, d, dc, rel, dly);
    ev_t e;
    e = '{k, a, d, dc, rel, dly};
    q.push_back(e);
  endtask

  task automatic push_head(input int ch, input logic [31:0] p, input int rel, dly);
    push(0, ch, 0, 0, rel, dly);
    if (p != 0) begin
      push(2, 2, int'(p[15:0]), 0, 0, 1);
      push(2, 3, int'(p[31:16]), 0, 0, 2);
      push(2, 0, 0, 0, 0, 3);
      push(2, 1, 5, 0, 0, 4);
    end
  endtask

  task automatic push_seq(input int ch, input logic [31:0] p, input int rel, dly);
    push_head(ch, p, rel, dly);
    if (p != 0) begin
      push(2, 0, 0, 0, 0, int'(p) + 7);
      push(1, ch, 0, 0, 0, int'(p) + 8);
    end else begin
      push(1, ch, 0, 0, 0, 1);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    if (!$onehot(v)) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_ev(input int k, a, d, dc);
    ev_t e;
    int want;
    checks++;
    evn++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL ev%0d: got kind=%0d a=%0d d=0x%0h at cyc %0d, required no event",
               evn, k, a, d, cyc);
    end else begin
      e = q.pop_front();
      want = ((e.rel == 0) ? last_g : last_d) + e.dly;
      if (e.kind != k || e.a != a || e.d != d || e.dc != dc ||
          (e.dly >= 0 && cyc != want)) begin
        errors++;
        $display("FAIL ev%0d: got kind=%0d a=%0d d=0x%0h dc=%0d cyc=%0d, required kind=%0d a=%0d d=0x%0h dc=%0d cyc=%0d",
                 evn, k, a, d, dc, cyc, e.kind, e.a, e.d, e.dc, want);
      end
    end
    if (k == 0) last_g = cyc;
    if (k == 1) last_d = cyc;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (grant != '0) chk_ev(0, oh_idx(grant), 0, 0);
      if (done != '0)  chk_ev(1, oh_idx(done), 0, int'(done_cancelled));
      if (tif.tmr_chipselect)
        chk_ev(2, int'(tif.tmr_address), int'(tif.tmr_writedata), int'(tif.tmr_write_n));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_dc"}, 32'(done_cancelled), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ach"}, 32'(active_ch), 0);
    chk({tag, "_cs"}, 32'(tif.tmr_chipselect), 0);
    chk({tag, "_wn"}, 32'(tif.tmr_write_n), 1);
    chk({tag, "_addr"}, 32'(tif.tmr_address), 0);
    chk({tag, "_wd"}, 32'(tif.tmr_writedata), 0);
  endtask

  task automatic wait_done(input int ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done[ch] && n < 70000);
    if (!done[ch]) begin
      checks++; errors++;
      $display("FAIL wait_done%0d: got no done after %0d cycles, required done", ch, n);
    end
    @(posedge clk); #1;
    req[ch] = 1'b0;
  endtask

  int g0 = 0;

  task automatic wait_grant(input int ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (!grant[ch] && n < 100);
    if (!grant[ch]) begin
      checks++; errors++;
      $display("FAIL wait_grant%0d: got no grant after %0d cycles, required grant", ch, n);
    end
    g0 = cyc;
  endtask

  // Move to #1 after the edge that starts cycle k counted from the grant.
  task automatic at(input int k);
    while (cyc < g0 + k) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    t_rst   = 1'b0;
    @(posedge clk); #1;

    // four channels at once, P=3: order 0..3, back-to-back grants
    for (int i = 0; i < N; i++) period[32*i +: 32] = 32'd3;
    push_seq(0, 3, 0, -1);
    push_seq(1, 3, 1, 1);
    push_seq(2, 3, 1, 1);
    push_seq(3, 3, 1, 1);
    req = 4'hF;
    for (int i = 0; i < N; i++) wait_done(i);
    // pointer wrapped to 0: req0 wins over req3
    push_seq(0, 3, 0, -1);
    push_seq(3, 3, 1, 1);
    req = 4'b1001;
    wait_done(0);
    wait_done(3);

    // single channel 1, P=10
    period[32*1 +: 32] = 32'd10;
    push_seq(1, 10, 0, -1);
    req[1] = 1'b1;
    wait_done(1);
    chk("irq_after_ack", 32'(tif.tmr_irq), 0);

    // 32-bit period spanning both halves
    period[32*2 +: 32] = 32'h0001_0002;
    push_seq(2, 32'h0001_0002, 0, -1);
    req[2] = 1'b1;
    wait_done(2);

    // cancel on channel 2 in WAIT_IRQ; stray cancels ignored
    period[32*2 +: 32] = 32'd1000;
    push_head(2, 1000, 0, -1);
    push(2, 1, 8, 0, 0, 56);
    push(2, 0, 0, 0, 0, 57);
    push(1, 2, 0, 1, 0, 58);
    req[2] = 1'b1;
    wait_grant(2);
    at(2);  cancel = 4'b0100;
    at(3);  cancel = 4'b0010;
    at(4);  cancel = 4'b0000;
    at(10); cancel = 4'b0010;
    at(11); cancel = 4'b0000;
    at(55); cancel = 4'b0100;
    at(56); cancel = 4'b0010;
    at(57); cancel = 4'b0000;
    wait_done(2);

    // P=0: immediate done, no bus traffic
    period[32*0 +: 32] = 32'd0;
    push_seq(0, 0, 0, -1);
    req[0] = 1'b1;
    wait_done(0);

    // irq and cancel in the same cycle: timeout wins
    period[32*3 +: 32] = 32'd4;
    push_seq(3, 4, 0, -1);
    req[3] = 1'b1;
    wait_grant(3);
    at(10);
    chk("irq_c10", 32'(tif.tmr_irq), 1);
    cancel = 4'b1000;
    at(11); cancel = 4'b0000;
    wait_done(3);

    // reset in WAIT_IRQ, then a request over a stale timeout
    period[32*1 +: 32] = 32'd20;
    push_head(1, 20, 0, -1);
    req[1] = 1'b1;
    wait_grant(1);
    at(10);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_ach", 32'(active_ch), 1);
    reset_n = 1'b0;
    req[1]  = 1'b0;
    at(11);
    chk_reset_vals("mid_rst");
    reset_n = 1'b1;
    at(40);
    chk("stale_irq", 32'(tif.tmr_irq), 1);
    period[32*1 +: 32] = 32'd5;
    push_seq(1, 5, 0, -1);
    req[1] = 1'b1;
    wait_done(1);
    chk("irq_after_stale", 32'(tif.tmr_irq), 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
